sysbus_core: RTL and testbench

SYSBUS_CORE -- requirements
Module: sysbus_core

---
 rtl/sysbus_core_if.sv | 38 +++
 rtl/sysbus_core.sv | 155 +++++++++++++++
 tb/tb_sysbus_core.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sysbus_core_if.sv
// ---------------------------------------------------------------------------
// sysbus_core_if -- request/response bus between sysbus_core and the system.
//
// Signals:
//   req      request address (valid while reqcyc is high)
//   reqtag   request tag
//   reqcyc   request valid
//   reqack   bus accepts the request
//   resp     response data beat
//   resptag  response tag
//   respcyc  response beat valid
//   respack  core consumes the response beat
//
// Modports: master = core side, slave = bus/memory side.
// ---------------------------------------------------------------------------
interface sysbus_core_if #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13
) ();
  logic [DATA_WIDTH-1:0] req;
  logic [TAG_WIDTH-1:0]  reqtag;
  logic                  reqcyc;
  logic                  reqack;
  logic [DATA_WIDTH-1:0] resp;
  logic [TAG_WIDTH-1:0]  resptag;
  logic                  respcyc;
  logic                  respack;

  modport master (
    output req, reqtag, reqcyc, respack,
    input  reqack, resp, resptag, respcyc
  );

  modport slave (
    input  req, reqtag, reqcyc, respack,
    output reqack, resp, resptag, respcyc
  );
endinterface

// File: rtl/sysbus_core.sv
// ---------------------------------------------------------------------------
// sysbus_core -- sequential cache-line fetcher.
//
// Starting from the 64-byte line containing `entry`, the core issues one read
// request per line (tag = {read, memory, id}), collects 8 matching 64-bit
// response beats into a line buffer, then moves on to the next line.
// Only one request is ever outstanding.
//
// Ports:
//   clk    in   sole clock, rising edge
//   reset  in   asynchronous, active-high reset
//   entry  in   64-bit start address, captured as the first line address
//   bus    --   sysbus_core_if.master (req/reqtag/reqcyc/reqack,
//               resp/resptag/respcyc/respack), pure wiring to the bus
//
// Optional feature (macro SYSBUS_CORE_DBG_EN):
//   dbg_valid out  one-cycle pulse per acknowledged beat, one cycle later
//   dbg_addr  out  line address + 8 * beat index of that beat
//   dbg_data  out  data of that beat
// ---------------------------------------------------------------------------
module sysbus_core #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [63:0]           entry,
  sysbus_core_if.master         bus
`ifdef SYSBUS_CORE_DBG_EN
  ,
  output logic                  dbg_valid,
  output logic [DATA_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, NEXT} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] line_q;
  logic [DATA_WIDTH-1:0] req_q;
  logic [TAG_WIDTH-1:0]  reqtag_q;
  logic                  reqcyc_q;
  logic [7:0]            id_q;
  logic [2:0]            beat_cnt_q;
  logic [DATA_WIDTH-1:0] line_buf_q [8];

  logic                  beat_ack_d;
  logic [TAG_WIDTH-1:0]  tag_d;
  logic [DATA_WIDTH-1:0] line_inc_d;

  // A beat is consumed only while waiting and only if it carries our tag;
  // everything else on the response channel is ignored.
  assign beat_ack_d = (state_q == WAIT) && bus.respcyc && (bus.resptag == reqtag_q);
  assign tag_d      = {1'b1, 4'b0001, id_q};
  assign line_inc_d = line_q + DATA_WIDTH'(64);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      line_q     <= '0;
      req_q      <= '0;
      reqtag_q   <= '0;
      reqcyc_q   <= 1'b0;
      id_q       <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // entry is captured on the first edge after reset releases, so a
          // new entry applied during reset always takes effect.
          line_q   <= {entry[63:6], 6'b0};
          req_q    <= {entry[63:6], 6'b0};
          reqtag_q <= tag_d;
          reqcyc_q <= 1'b1;
          state_q  <= REQ;
        end
        REQ: begin
          if (bus.reqack) begin
            reqcyc_q <= 1'b0;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (beat_ack_d) begin
            if (beat_cnt_q == 3'd7) begin
              beat_cnt_q <= '0;
              id_q       <= id_q + 8'd1;
              line_q     <= line_inc_d;
              state_q    <= NEXT;
            end else begin
              beat_cnt_q <= beat_cnt_q + 3'd1;
            end
          end
        end
        NEXT: begin
          req_q    <= line_q;
          reqtag_q <= tag_d;
          reqcyc_q <= 1'b1;
          state_q  <= REQ;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line buffer: one register per word so the whole line clears on reset.
  logic [8*DATA_WIDTH-1:0] line_buf_flat;

  for (genvar gi = 0; gi < 8; gi++) begin : g_line_buf
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        line_buf_q[gi] <= '0;
      end else if (beat_ack_d && (beat_cnt_q == 3'(gi))) begin
        line_buf_q[gi] <= bus.resp;
      end
    end
    assign line_buf_flat[gi*DATA_WIDTH +: DATA_WIDTH] = line_buf_q[gi];
  end

  // The line buffer has no consumer inside this block and the low entry bits
  // are dropped by line alignment; fold them into one named sink.
  logic unused_bits;
  assign unused_bits = ^{entry[5:0], line_buf_flat};

  assign bus.req     = req_q;
  assign bus.reqtag  = reqtag_q;
  assign bus.reqcyc  = reqcyc_q;
  assign bus.respack = beat_ack_d;

`ifdef SYSBUS_CORE_DBG_EN
  logic                  dbg_valid_q;
  logic [DATA_WIDTH-1:0] dbg_addr_q;
  logic [DATA_WIDTH-1:0] dbg_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbg_valid_q <= 1'b0;
      dbg_addr_q  <= '0;
      dbg_data_q  <= '0;
    end else begin
      dbg_valid_q <= beat_ack_d;
      if (beat_ack_d) begin
        dbg_addr_q <= line_q + DATA_WIDTH'({beat_cnt_q, 3'b000});
        dbg_data_q <= bus.resp;
      end
    end
  end

  assign dbg_valid = dbg_valid_q;
  assign dbg_addr  = dbg_addr_q;
  assign dbg_data  = dbg_data_q;
`endif

endmodule

// File: tb/tb_sysbus_core.sv
module tb_sysbus_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry;

  always #5 clk = ~clk;

  sysbus_core_if #(.DATA_WIDTH(64), .TAG_WIDTH(13)) bus ();

`ifdef SYSBUS_CORE_DBG_EN
  logic        dbg_valid;
  logic [63:0] dbg_addr;
  logic [63:0] dbg_data;
`endif

  sysbus_core #(.DATA_WIDTH(64), .TAG_WIDTH(13)) dut (
    .clk   (clk),
    .reset (reset),
    .entry (entry),
    .bus   (bus)
`ifdef SYSBUS_CORE_DBG_EN
    ,
    .dbg_valid (dbg_valid),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
`endif
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [63:0] addr;
    logic [12:0] tag;
  } req_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
  } dbg_t;

  req_t exp_req_q[$];
  bit   exp_ack_q[$];
  dbg_t exp_dbg_q[$];

  // Reference model: the n-th line after (re)start lives at
  // align64(entry) + 64*n and carries tag 0x1100 + (n mod 256).
  logic [63:0] m_line;
  int          m_id;

  function automatic logic [12:0] model_tag(input int id);
    return 13'h1100 + 13'(id % 256);
  endfunction

  function automatic req_t model_req();
    req_t r;
    r.addr = m_line;
    r.tag  = model_tag(m_id);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h at %0t", name, act, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_all();
    exp_req_q.delete();
    exp_ack_q.delete();
    exp_dbg_q.delete();
  endtask

  // ------------------------------------------------------------------ monitor
  logic        prev_reqcyc = 1'b0;
  logic        pend_drop   = 1'b0;
  req_t        cur_req;

  always @(negedge clk) begin
    if (reset) begin
      prev_reqcyc = 1'b0;
      pend_drop   = 1'b0;
    end else begin
      if (pend_drop) begin
        check("reqcyc_drop_after_ack", 64'(bus.reqcyc), 64'd0);
        pend_drop = 1'b0;
      end
      if (bus.reqcyc && !prev_reqcyc) begin
        if (exp_req_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL req_unexpected: got req=0x%0h tag=0x%0h, want no request", bus.req, bus.reqtag);
          cur_req = '0;
        end else begin
          cur_req = exp_req_q.pop_front();
          check("req_addr", bus.req, cur_req.addr);
          check("req_tag", 64'(bus.reqtag), 64'(cur_req.tag));
        end
      end else if (bus.reqcyc && prev_reqcyc) begin
        check("req_hold_addr", bus.req, cur_req.addr);
        check("req_hold_tag", 64'(bus.reqtag), 64'(cur_req.tag));
      end
      if (bus.reqcyc && bus.reqack) pend_drop = 1'b1;
      prev_reqcyc = bus.reqcyc;

      if (bus.respcyc) begin
        if (exp_ack_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL beat_unexpected: got respack=%0b, want no beat", bus.respack);
        end else begin
          check("respack", 64'(bus.respack), 64'(exp_ack_q.pop_front()));
        end
      end
`ifdef SYSBUS_CORE_DBG_EN
      if (dbg_valid) begin
        if (exp_dbg_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL dbg_unexpected: got addr=0x%0h data=0x%0h, want no pulse", dbg_addr, dbg_data);
        end else begin
          dbg_t d;
          d = exp_dbg_q.pop_front();
          check("dbg_addr", dbg_addr, d.addr);
          check("dbg_data", dbg_data, d.data);
        end
      end
`endif
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic drive_beat(input logic [12:0] tag, input logic [63:0] data, input bit exp_ack);
    bus.respcyc = 1'b1;
    bus.resptag = tag;
    bus.resp    = data;
    exp_ack_q.push_back(exp_ack);
  endtask

  task automatic run_line(input int ack_delay, input bit gapped, input bit seq_data,
                          input bit spurious, input int stop_after);
    int          n;
    int          k;
    logic [12:0] tag;
    logic [12:0] bad;
    logic [63:0] base;
    logic [63:0] data;
    dbg_t        d;
    tag  = model_tag(m_id);
    base = m_line;
    bad  = (tag == 13'h1155) ? 13'h1156 : 13'h1155;
    n = 0;
    while (bus.reqcyc !== 1'b1) begin
      if (n >= 60) begin
        checks++; failures++;
        $display("FAIL req_timeout: got reqcyc=%0b for 60 cycles, want 1", bus.reqcyc);
        finish_tb();
        return;
      end
      step();
      n++;
    end
    for (int i = 0; i < ack_delay; i++) begin
      if (spurious) drive_beat(tag, {$urandom, $urandom}, 1'b0);
      step();
      bus.respcyc = 1'b0;
    end
    bus.reqack = 1'b1;
    if (spurious) drive_beat(tag, {$urandom, $urandom}, 1'b0);
    step();
    bus.reqack  = 1'b0;
    bus.respcyc = 1'b0;
    if (gapped) begin
      drive_beat(bad, {$urandom, $urandom}, 1'b0);
      step();
      bus.respcyc = 1'b0;
    end
    k = 0;
    while (k < stop_after) begin
      if (gapped && $urandom_range(0, 2) == 0) begin
        bus.respcyc = 1'b0;
      end else if (gapped && $urandom_range(0, 4) == 0) begin
        drive_beat(bad, {$urandom, $urandom}, 1'b0);
      end else begin
        data = seq_data ? 64'(k) : {$urandom, $urandom};
        drive_beat(tag, data, 1'b1);
`ifdef SYSBUS_CORE_DBG_EN
        d.addr = base + 64'(8 * k);
        d.data = data;
        exp_dbg_q.push_back(d);
`endif
        k++;
      end
      step();
      bus.respcyc = 1'b0;
    end
    if (stop_after < 8) return;
    m_line = m_line + 64'd64;
    m_id++;
    exp_req_q.push_back(model_req());
    check("next_cycle_reqcyc", 64'(bus.reqcyc), 64'd0);
    if (spurious) drive_beat(tag, {$urandom, $urandom}, 1'b0);
    step();
    bus.respcyc = 1'b0;
    check("req_after_next", 64'(bus.reqcyc), 64'd1);
  endtask

  initial begin
    logic [12:0] tag;
    reset       = 1'b1;
    entry       = 64'h1000_0007;
    bus.reqack  = 1'b0;
    bus.respcyc = 1'b0;
    bus.resptag = '0;
    bus.resp    = '0;
    step();
    step();
    check("reset_reqcyc", 64'(bus.reqcyc), 64'd0);
    check("reset_respack", 64'(bus.respack), 64'd0);
    check("reset_req", bus.req, 64'd0);
    check("reset_reqtag", 64'(bus.reqtag), 64'd0);

    m_line = entry & ~64'h3f;
    m_id   = 0;
    exp_req_q.push_back(model_req());
    reset = 1'b0;

    run_line(2, 1'b0, 1'b1, 1'b0, 8);   // ack on 3rd REQ cycle, data 0..7
    run_line(0, 1'b1, 1'b0, 1'b0, 8);   // gapped burst with a 0x1155 beat
    for (int l = 2; l < 256; l++)
      run_line($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 8);

    // 257th request (tag wraps to 0x1100), reset after 4 beats
    run_line(1, 1'b0, 1'b1, 1'b0, 4);
    tag = model_tag(m_id);
    drive_beat(tag, 64'h55, 1'b1);
    #5;
    check("respack_before_reset", 64'(bus.respack), 64'd1);
    reset = 1'b1;
    #1;
    check("respack_async_drop", 64'(bus.respack), 64'd0);
    check("reqcyc_async_drop", 64'(bus.reqcyc), 64'd0);
    check("req_async_clear", bus.req, 64'd0);
    check("reqtag_async_clear", 64'(bus.reqtag), 64'd0);
    bus.respcyc = 1'b0;
    flush_all();
    entry = 64'h2000;
    step();
    step();
    m_line = 64'h2000;
    m_id   = 0;
    exp_req_q.push_back(model_req());
    reset = 1'b0;
    run_line(1, 1'b0, 1'b0, 1'b0, 8);

    // reset while a request is being presented
    #5;
    check("reqcyc_before_reset", 64'(bus.reqcyc), 64'd1);
    reset = 1'b1;
    #1;
    check("reqcyc_async_drop_req", 64'(bus.reqcyc), 64'd0);
    flush_all();
    entry = 64'h3000_0010;
    step();
    m_line = 64'h3000_0000;
    m_id   = 0;
    exp_req_q.push_back(model_req());
    reset = 1'b0;
    run_line(2, 1'b1, 1'b0, 1'b1, 8);

    step();
    step();
    check("req_queue_drained", 64'(exp_req_q.size()), 64'd0);
    check("beat_queue_drained", 64'(exp_ack_q.size()), 64'd0);
`ifdef SYSBUS_CORE_DBG_EN
    check("dbg_queue_drained", 64'(exp_dbg_q.size()), 64'd0);
`endif
    finish_tb();
  end

endmodule
